// File: rtl/delay_sched.sv
// Round-robin owner of a single (len+1)-cycle delay timer shared by NUM_REQ requesters.
// Handshake: a requester holds req until its done pulse and drops it the cycle after.
module delay_sched #(
  parameter int NUM_REQ       = 4,
  parameter int COUNTER_WIDTH = 10,
  localparam int IDW          = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*COUNTER_WIDTH-1:0] req_len,
  output logic [NUM_REQ-1:0]               grant,
  output logic [NUM_REQ-1:0]               done,
  output logic                             busy,
  output logic [IDW-1:0]                   active_id,
  output logic [1:0]                       state_dbg
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] COUNT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [1:0]               state;
  logic [COUNTER_WIDTH-1:0] counter;
  logic [COUNTER_WIDTH-1:0] len;
  logic [IDW-1:0]           ptr;
  logic [IDW-1:0]           sel;
  logic [IDW-1:0]           next_ptr;
  logic [NUM_REQ-1:0]       sel_onehot;
  logic                     found;
  int                       idx;

  // Search starts at ptr so the last owner sits at the lowest priority.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = IDW'(idx);
      end
    end
  end

  assign sel_onehot = ONE << sel;
  assign next_ptr   = (active_id == IDW'(NUM_REQ - 1)) ? '0 : active_id + IDW'(1);
  assign busy       = (state != IDLE);
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      counter   <= '0;
      len       <= '0;
      ptr       <= '0;
      grant     <= '0;
      done      <= '0;
      active_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          grant <= '0;
          done  <= '0;
          if (found) begin
            len       <= req_len[int'(sel)*COUNTER_WIDTH +: COUNTER_WIDTH];
            counter   <= '0;
            grant     <= sel_onehot;
            active_id <= sel;
            state     <= COUNT;
          end
        end
        COUNT: begin
          // Compare before increment keeps counter <= len, so len = max never wraps.
          if (counter == len) begin
            state <= DONE;
            grant <= '0;
            done  <= grant;
          end else begin
            counter <= counter + COUNTER_WIDTH'(1);
          end
        end
        DONE: begin
          done  <= '0;
          ptr   <= next_ptr;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          done  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_delay_sched.sv
// Bench for delay_sched: directed timing steps plus randomized traffic against a timeline model.
module tb_delay_sched;
  localparam int N   = 4;
  localparam int CW  = 10;
  localparam int IDW = 2;
  localparam int W   = 2*N + 1 + IDW;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    req;
  logic [N*CW-1:0] req_len;
  logic [N-1:0]    grant, done;
  logic            busy;
  logic [IDW-1:0]  active_id;
  logic [1:0]      state_dbg;

  logic [2:0]      req3;
  logic [3*CW-1:0] req_len3;
  logic [2:0]      grant3, done3;
  logic            busy3;
  logic [1:0]      active_id3;
  logic [1:0]      state_dbg3;

  delay_sched #(.NUM_REQ(N), .COUNTER_WIDTH(CW)) u_dut (
    .clk(clk), .rst(rst), .req(req), .req_len(req_len), .grant(grant), .done(done),
    .busy(busy), .active_id(active_id), .state_dbg(state_dbg)
  );

  delay_sched #(.NUM_REQ(3), .COUNTER_WIDTH(CW)) u_dut3 (
    .clk(clk), .rst(rst), .req(req3), .req_len(req_len3), .grant(grant3), .done(done3),
    .busy(busy3), .active_id(active_id3), .state_dbg(state_dbg3)
  );

  int total = 0;
  int bad   = 0;

  // timeline model: one service = grant for len+1 cycles, done the next, idle after
  int cyc = 0;
  bit m_act = 0;
  int m_start, m_len, m_owner;
  int m_ptr = 0;
  int m_last = 0;
  logic [W-1:0] exp_q[$];

  int g_at[N];
  int d_at[N];
  int base;
  bit auto_drop;
  int glog[$];
  int glog3[$];
  logic [N-1:0] prev_grant = '0;
  logic [2:0]   prev_grant3 = '0;

  function automatic int oh_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic set_len(input int i, input int v);
    req_len[i*CW +: CW] = CW'(v);
  endtask

  task automatic model_update();
    int c;
    int off;
    logic [N-1:0] g, d;
    c = cyc + 1;
    if (rst) begin
      m_act  = 0;
      m_ptr  = 0;
      m_last = 0;
    end else if (m_act) begin
      if (c - m_start == m_len + 2) begin
        m_act = 0;
        m_ptr = (m_owner + 1) % N;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!m_act && req[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          m_act   = 1;
          m_start = c;
          m_len   = int'(req_len[m_owner*CW +: CW]);
          m_last  = m_owner;
        end
      end
    end
    g = '0;
    d = '0;
    if (m_act) begin
      off = c - m_start;
      if (off <= m_len) g[m_owner] = 1'b1;
      if (off == m_len + 1) d[m_owner] = 1'b1;
    end
    exp_q.push_back({g, d, m_act, IDW'(m_last)});
    cyc = c;
  endtask

  task automatic check_out();
    logic [W-1:0] e, o;
    e = exp_q.pop_front();
    o = {grant, done, busy, active_id};
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL outputs cyc=%0d observed=%h expected=%h", cyc, o, e);
    end
  endtask

  task automatic check_int(input string tag, input int o, input int e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    @(negedge clk);
    check_out();
    if (grant != '0 && prev_grant == '0) glog.push_back(oh_idx(grant));
    if (grant3 != '0 && prev_grant3 == '0) glog3.push_back(oh_idx({1'b0, grant3}));
    prev_grant  = grant;
    prev_grant3 = grant3;
  endtask

  task automatic start_window();
    base = cyc;
    for (int i = 0; i < N; i++) begin
      g_at[i] = -1;
      d_at[i] = -1;
    end
    glog.delete();
    glog3.delete();
  endtask

  // driver: advance n cycles, record first grant/done per requester, apply the drop handshake
  task automatic run(input int n);
    for (int t = 0; t < n; t++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (grant[i] && g_at[i] < 0) g_at[i] = cyc - base;
        if (done[i] && d_at[i] < 0) d_at[i] = cyc - base;
        if (done[i] && auto_drop) req[i] = 1'b0;
      end
      for (int i = 0; i < 3; i++) if (done3[i] && auto_drop) req3[i] = 1'b0;
    end
  endtask

  initial begin
    int exp_order[5];
    int rst_cycle;
    exp_order = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    req = '0;
    req_len = '0;
    req3 = '0;
    req_len3 = '0;
    auto_drop = 1'b1;
    run(2);
    rst = 1'b0;
    run(1);

    // single requester, len 5
    req[0] = 1'b1; set_len(0, 5);
    start_window(); run(9);
    check_int("single_grant", g_at[0], 1);
    check_int("single_done", d_at[0], 7);
    check_int("single_busy_low", int'(busy), 0);

    // len 0
    req[1] = 1'b1; set_len(1, 0);
    start_window(); run(4);
    check_int("len0_grant", g_at[1], 1);
    check_int("len0_done", d_at[1], 2);

    // len max
    req[2] = 1'b1; set_len(2, 1023);
    start_window(); run(1028);
    check_int("lenmax_grant", g_at[2], 1);
    check_int("lenmax_done", d_at[2], 1025);

    // inputs ignored during COUNT
    req[1] = 1'b1; set_len(1, 4);
    start_window(); run(3);
    req[1] = 1'b0; set_len(1, 9);
    run(6);
    check_int("ignore_done", d_at[1], 6);

    // fairness from ptr 0 with drop after done
    rst = 1'b1; run(2); rst = 1'b0;
    req = '1;
    for (int i = 0; i < N; i++) set_len(i, 2);
    start_window(); run(22);
    check_int("fair_g0", g_at[0], 1);
    check_int("fair_g1", g_at[1], 6);
    check_int("fair_g2", g_at[2], 11);
    check_int("fair_g3", g_at[3], 16);

    // continuous requests
    auto_drop = 1'b0;
    req = '1;
    start_window(); run(24);
    check_int("cont_count", glog.size(), 5);
    for (int k = 0; k < 5 && k < glog.size(); k++) check_int("cont_order", glog[k], exp_order[k]);
    req = '0;
    auto_drop = 1'b1;
    run(8);

    // reset in the middle of a len 8 delay
    req[0] = 1'b1; set_len(0, 8);
    start_window(); run(3);
    rst = 1'b1; req = '0;
    run(1);
    check_int("rst_grant", int'(grant), 0);
    check_int("rst_done", int'(done), 0);
    check_int("rst_busy", int'(busy), 0);
    check_int("rst_active_id", int'(active_id), 0);
    rst = 1'b0;
    rst_cycle = cyc - base;
    req[2] = 1'b1; set_len(2, 1);
    run(7);
    check_int("rst_no_done", d_at[0], -1);
    check_int("rst_new_grant", g_at[2] - rst_cycle, 1);

    // NUM_REQ=3: advance ptr to 2, then {2,0} pending
    req3 = 3'b011;
    start_window(); run(8);
    req3 = 3'b101;
    start_window(); run(8);
    check_int("wrap_count", glog3.size(), 2);
    if (glog3.size() == 2) begin
      check_int("wrap_first", glog3[0], 2);
      check_int("wrap_second", glog3[1], 0);
    end
    check_int("wrap_active_id", int'(active_id3), 0);

    // randomized traffic
    auto_drop = 1'b0;
    for (int t = 0; t < 500; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          set_len(i, int'($urandom_range(0, 6)));
        end else if ($urandom_range(0, 7) == 0) begin
          set_len(i, int'($urandom_range(0, 6)));
        end
      end
      rst = ($urandom_range(0, 149) == 0);
      run(1);
      for (int i = 0; i < N; i++) if (done[i] && $urandom_range(0, 3) != 0) req[i] = 1'b0;
    end
    rst = 1'b0;
    req = '0;
    run(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
